// File: rtl/nand_bit_deserializer_if.sv
// Word-side valid/ready port of the NAND bit deserializer.
// The master drives the assembled word. The slave consumes it.
interface nand_bit_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output word_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/nand_bit_deserializer.sv
// Packs the NAND pipeline's 1-bit result stream into WIDTH-bit words behind a single-entry output slot.
// The serial side never stalls: a completed word that cannot be stored is dropped and flagged in overflow.
module nand_bit_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     resync,
    output logic [$clog2(WIDTH):0]   fill_count,
    output logic                     overflow,
    input  logic                     overflow_clr,
    nand_bit_deserializer_if.master  wp
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t             state, state_nx;
    logic [WIDTH-1:0]  shreg, shreg_nx, shifted;
    logic [WIDTH-1:0]  word_q, word_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              ovf_q, ovf_nx;
    logic              accept, complete, drop;

    assign accept   = bit_valid & ~resync;
    assign complete = accept && (cnt == CW'(WIDTH - 1));
    assign shifted  = LSB_FIRST ? {bit_in, shreg[WIDTH-1:1]}
                                : {shreg[WIDTH-2:0], bit_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            shreg  <= '0;
            word_q <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            word_q <= word_nx;
            cnt    <= cnt_nx;
            ovf_q  <= ovf_nx;
        end
    end

    always_comb begin
        shreg_nx = shreg;
        cnt_nx   = cnt;
        state_nx = state;
        word_nx  = word_q;
        drop     = 1'b0;

        if (resync) begin
            shreg_nx = '0;
            cnt_nx   = '0;
        end else if (accept) begin
            shreg_nx = shifted;
            cnt_nx   = complete ? '0 : cnt + CW'(1);
        end

        // A handshake on the completing edge frees the slot just in time to take the new word.
        unique case (state)
            EMPTY: begin
                if (complete) begin
                    state_nx = FULL;
                    word_nx  = shifted;
                end
            end
            FULL: begin
                if (complete) begin
                    if (wp.word_ready) word_nx = shifted;
                    else               drop    = 1'b1;
                end else if (wp.word_ready) begin
                    state_nx = EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase

        ovf_nx = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    end

    assign wp.word_out   = word_q;
    assign wp.word_valid = (state == FULL);
    assign fill_count    = cnt;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_nand_bit_deserializer.sv
// Self-checking bench: two WIDTH=4 deserializers (LSB_FIRST=1 and 0) share one stimulus stream.
// A cycle table drives and checks them, and a hand-written sequence covers asynchronous reset.
module tb_nand_bit_deserializer;
    logic clk = 1'b0;
    logic rst, bit_in, bit_valid, resync, overflow_clr, rdy;
    logic [2:0] fill_a, fill_b;
    logic       ovf_a, ovf_b;

    nand_bit_deserializer_if #(.WIDTH(4)) ia ();
    nand_bit_deserializer_if #(.WIDTH(4)) ib ();
    assign ia.word_ready = rdy;
    assign ib.word_ready = rdy;

    nand_bit_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .resync(resync),
        .fill_count(fill_a), .overflow(ovf_a), .overflow_clr(overflow_clr), .wp(ia.master));
    nand_bit_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .resync(resync),
        .fill_count(fill_b), .overflow(ovf_b), .overflow_clr(overflow_clr), .wp(ib.master));

    always #5 clk = ~clk;

    typedef struct {
        logic       bi, bv, rs, rd, clr, push;
        logic [3:0] wa, wb;
        logic [2:0] ef;
        logic       ev, eo;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    logic [3:0] held_a, held_b;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic bi, bv, rs, rd, clr, push,
                       input logic [3:0] wa, wb, input logic [2:0] ef, input logic ev, eo);
        vec_t v;
        v.bi = bi; v.bv = bv; v.rs = rs; v.rd = rd; v.clr = clr; v.push = push;
        v.wa = wa; v.wb = wb; v.ef = ef; v.ev = ev; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic bi, bv, rs, rd, clr);
        bit_in = bi; bit_valid = bv; resync = rs; rdy = rd; overflow_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid_a"}, int'(ia.word_valid), 0);
        chk({tag, "_valid_b"}, int'(ib.word_valid), 0);
        chk({tag, "_word_a"},  int'(ia.word_out), 0);
        chk({tag, "_word_b"},  int'(ib.word_out), 0);
        chk({tag, "_fill_a"},  int'(fill_a), 0);
        chk({tag, "_fill_b"},  int'(fill_b), 0);
        chk({tag, "_ovf_a"},   int'(ovf_a), 0);
        chk({tag, "_ovf_b"},   int'(ovf_b), 0);
    endtask

    initial begin
        rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; resync = 1'b0;
        overflow_clr = 1'b0; rdy = 1'b0;
        held_a = '0; held_b = '0;

        // bi bv rs rd clr push wa wb fill valid ovf
        add(1,1,0,1,0,0,4'h0,4'h0,1,0,0);
        add(0,1,0,1,0,0,4'h0,4'h0,2,0,0);
        add(1,1,0,1,0,0,4'h0,4'h0,3,0,0);
        add(1,1,0,1,0,1,4'b1101,4'b1011,0,1,0);
        add(0,0,0,1,0,0,4'h0,4'h0,0,0,0);
        add(1,1,0,1,0,0,4'h0,4'h0,1,0,0);
        add(1,1,0,1,0,0,4'h0,4'h0,2,0,0);
        add(1,1,1,1,0,0,4'h0,4'h0,0,0,0);
        add(0,1,0,1,0,0,4'h0,4'h0,1,0,0);
        add(0,1,0,1,0,0,4'h0,4'h0,2,0,0);
        add(1,0,0,1,0,0,4'h0,4'h0,2,0,0);
        add(0,1,0,1,0,0,4'h0,4'h0,3,0,0);
        add(1,1,0,1,0,1,4'b1000,4'b0001,0,1,0);
        add(0,0,0,1,0,0,4'h0,4'h0,0,0,0);
        add(1,1,0,0,0,0,4'h0,4'h0,1,0,0);
        add(0,1,0,0,0,0,4'h0,4'h0,2,0,0);
        add(1,1,0,0,0,0,4'h0,4'h0,3,0,0);
        add(0,1,0,0,0,1,4'b0101,4'b1010,0,1,0);
        add(0,1,0,0,0,0,4'h0,4'h0,1,1,0);
        add(1,1,0,0,0,0,4'h0,4'h0,2,1,0);
        add(0,1,0,0,0,0,4'h0,4'h0,3,1,0);
        add(0,1,0,1,0,1,4'b0010,4'b0100,0,1,0);
        add(0,0,0,1,0,0,4'h0,4'h0,0,0,0);
        add(1,1,0,0,0,0,4'h0,4'h0,1,0,0);
        add(1,1,0,0,0,0,4'h0,4'h0,2,0,0);
        add(1,1,0,0,0,0,4'h0,4'h0,3,0,0);
        add(1,1,0,0,0,1,4'b1111,4'b1111,0,1,0);
        add(0,1,0,0,0,0,4'h0,4'h0,1,1,0);
        add(0,1,0,0,0,0,4'h0,4'h0,2,1,0);
        add(0,1,0,0,0,0,4'h0,4'h0,3,1,0);
        add(0,1,0,0,0,0,4'h0,4'h0,0,1,1);
        add(0,0,0,0,1,0,4'h0,4'h0,0,1,0);
        add(1,1,0,0,0,0,4'h0,4'h0,1,1,0);
        add(0,1,0,0,0,0,4'h0,4'h0,2,1,0);
        add(1,1,0,0,0,0,4'h0,4'h0,3,1,0);
        add(0,1,0,0,1,0,4'h0,4'h0,0,1,1);
        add(0,0,0,0,1,0,4'h0,4'h0,0,1,0);
        add(0,0,0,1,0,0,4'h0,4'h0,0,0,0);
        add(0,0,0,1,0,0,4'h0,4'h0,0,0,0);

        #12;
        chk_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].push) sb.push_back({tbl[i].wa, tbl[i].wb});
            drive(tbl[i].bi, tbl[i].bv, tbl[i].rs, tbl[i].rd, tbl[i].clr);
            if (tbl[i].push) begin
                if (sb.size() == 0) begin
                    chk($sformatf("row%0d_sb_empty", i), 0, 1);
                end else begin
                    {held_a, held_b} = sb.pop_front();
                end
            end
            chk($sformatf("row%0d_fill_a", i),  int'(fill_a), int'(tbl[i].ef));
            chk($sformatf("row%0d_fill_b", i),  int'(fill_b), int'(tbl[i].ef));
            chk($sformatf("row%0d_valid_a", i), int'(ia.word_valid), int'(tbl[i].ev));
            chk($sformatf("row%0d_valid_b", i), int'(ib.word_valid), int'(tbl[i].ev));
            chk($sformatf("row%0d_ovf_a", i),   int'(ovf_a), int'(tbl[i].eo));
            chk($sformatf("row%0d_ovf_b", i),   int'(ovf_b), int'(tbl[i].eo));
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_word_a", i), int'(ia.word_out), int'(held_a));
                chk($sformatf("row%0d_word_b", i), int'(ib.word_out), int'(held_b));
            end
        end
        chk("sb_drained", sb.size(), 0);

        // Hold a word (1,0,1,1), then two more bits, then drop reset between edges.
        drive(1,1,0,0,0);
        drive(0,1,0,0,0);
        drive(1,1,0,0,0);
        drive(1,1,0,0,0);
        drive(1,1,0,0,0);
        drive(1,1,0,0,0);
        bit_valid = 1'b0;
        chk("pre_rst_valid_a", int'(ia.word_valid), 1);
        chk("pre_rst_word_a",  int'(ia.word_out), 4'b1101);
        chk("pre_rst_word_b",  int'(ib.word_out), 4'b1011);
        chk("pre_rst_fill_a",  int'(fill_a), 2);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        rst = 1'b1;
        drive(0,0,0,0,0);
        chk_zero("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nand_bit_deserializer.md
Name: nand_bit_deserializer

Overview:
- Downstream consumer of the pipelined NAND stage: samples its 1-bit result stream `c` and packs consecutive valid bits into WIDTH-bit words.
- Presents each word on a valid/ready output port.
- The serial side cannot stall, because the NAND pipeline has no backpressure. A completed word that cannot be stored is dropped and flagged.
- Sits between the NAND pipeline and word-oriented checkers/monitors in the example testbenches.

Parameters:
- WIDTH, 8: bits per output word; legal range 2..32.
- LSB_FIRST, 1: 1 = first received bit lands in word bit 0; 0 = first received bit lands in bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- bit_in  input  1  serial data bit (NAND stage output `c`)
- bit_valid  input  1  bit_in is sampled on this clock edge
- resync  input  1  discard partially assembled word
- word_out  output  WIDTH  assembled word
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  consumer accepts word_out
- fill_count  output  $clog2(WIDTH)+1  bits currently held in the shift register
- overflow  output  1  sticky: a completed word was dropped
- overflow_clr  input  1  clears overflow

Behaviour:
- Reset (rst=0, asynchronous): shift register=0, fill_count=0, word_out=0, word_valid=0, overflow=0. Reset asserted mid-word discards the partial word and any held word.
- Bit accept: on a clk edge with bit_valid=1 and resync=0, bit_in is shifted in and fill_count increments.
  - LSB_FIRST=1: shift right, new bit enters at MSB; after WIDTH bits the first bit sits at bit 0.
  - LSB_FIRST=0: shift left, new bit enters at bit 0.
- Completion: the accept that takes fill_count from WIDTH-1 to WIDTH completes the word.
  - On that same edge fill_count wraps to 0.
  - The completed word (including the current bit) is the load candidate.
- Output slot is one register with two states:
  - EMPTY (word_valid=0): a completion loads word_out and sets word_valid=1 on that edge. word_out becomes visible the cycle after the last bit's edge; latency from the last bit sampled to word_valid high is 1 cycle.
  - FULL (word_valid=1): word_out and word_valid are held stable until word_ready=1. A handshake (word_valid & word_ready) at an edge with no completion sets word_valid=0.
- Simultaneous handshake and completion at the same edge: the slot is freed and reloaded. word_valid stays 1, word_out takes the new word, and there is no overflow.
- Completion while FULL and word_ready=0: the new word is dropped and overflow is set to 1. The held word_out is unchanged and fill_count still wraps to 0.
- overflow is sticky.
  - overflow_clr=1 clears it at the edge.
  - If overflow_clr and a new drop coincide, overflow=1 (set wins).
- resync=1: fill_count=0 and the shift register is cleared at the edge. bit_valid is ignored in that cycle. The output slot, word_valid and overflow are unaffected.
- bit_valid=0: no shift and no count change. Gaps between bits are allowed and do not affect assembly.
- word_ready while word_valid=0 is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=4, LSB_FIRST=1. Release rst, then bits 1,0,1,1 on 4 consecutive cycles with word_ready=1. Required: word_out=4'b1101, word_valid=1 for exactly 1 cycle starting the cycle after the 4th bit, fill_count sequence 1,2,3,0.
- Same stream with LSB_FIRST=0. Required: word_out=4'b1011.
- WIDTH=4, word_ready=0. Stream 8 bits 1,1,1,1,0,0,0,0. Required: word_out=4'b1111 held, overflow=1 after the 8th bit. Then pulse overflow_clr with no drop: overflow=0 and word_out still 4'b1111.
- WIDTH=4. First word pending and word_ready asserted exactly on the edge of the 4th bit of the second word 0,1,0,0. Required: word_valid stays 1, word_out becomes 4'b0010, overflow=0.
- Bits 1,1 then resync=1, then bits 0,0,0,1. Required: word_out=4'b1000, and fill_count reads 0 the cycle after resync.
- Assert rst=0 asynchronously between clock edges while word_valid=1 and fill_count=2. Required: word_valid, word_out, fill_count and overflow all 0 immediately, before the next edge.
